fetch_req_buffer: RTL and testbench

//  Sits directly downstream of fetch. Queues fetch requests (buff_rd_en/addr/tag),

---
 rtl/fetch_req_buffer.sv | 113 +++++++++++
 tb/tb_fetch_req_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_req_buffer.sv
// fetch_req_buffer: queues fetch requests, serialises them to instruction memory
// (one outstanding access) and returns instructions to the wavepool with completion acks.
module fetch_req_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 39
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buff_rd_en,
  input  logic [ADDR_W-1:0] buff_addr,
  input  logic [TAG_W-1:0]  buff_tag,
  output logic              buff_ack,
  input  logic              flush_en,
  input  logic [5:0]        flush_wfid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              fetchwave_ack,
  output logic [5:0]        fetch_wfid,
  output logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_instr,
  output logic              fetch_first,
  output logic              overflow_err
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [TAG_W-1:0]  fifo_tag [DEPTH];
  logic [DEPTH-1:0]  fifo_kill;
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count;
  logic [TAG_W-1:0]  hold_tag;
  logic              hold_kill;
  logic              empty, full, avail, pop, push, done, load, hold_hit, deliver, src_kill;
  logic [ADDR_W-1:0] src_addr;
  logic [TAG_W-1:0]  src_tag;
  // The head entry stays queued until granted; an empty queue bypasses the incoming request.
  always_comb begin
    empty    = count == '0;
    full     = count == (PW+1)'(DEPTH);
    avail    = !empty || buff_rd_en;
    pop      = state == REQ && mem_gnt;
    push     = buff_rd_en && (!full || pop);
    done     = state == WAIT && mem_rsp_valid;
    load     = (state == IDLE || done) && avail;
    src_addr = empty ? buff_addr : fifo_addr[head];
    src_tag  = empty ? buff_tag : fifo_tag[head];
    src_kill = !empty && (fifo_kill[head] || (flush_en && fifo_tag[head][37:32] == flush_wfid));
    hold_hit = flush_en && hold_tag[37:32] == flush_wfid;
    deliver  = done && !hold_kill && !hold_hit;
  end
  always_comb begin
    state_nx = state == IDLE ? (avail ? REQ : IDLE) :
               state == REQ  ? (mem_gnt ? WAIT : REQ) :
               mem_rsp_valid ? (avail ? REQ : IDLE) : WAIT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) begin
      fifo_addr[tail] <= buff_addr;
      fifo_tag[tail]  <= buff_tag;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      fifo_kill    <= '0;
      overflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (flush_en && fifo_tag[i][37:32] == flush_wfid) fifo_kill[i] <= 1'b1;
      if (push) begin
        fifo_kill[tail] <= 1'b0;
        tail            <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (buff_rd_en && !push) overflow_err <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      hold_tag      <= '0;
      hold_kill     <= 1'b0;
      buff_ack      <= 1'b0;
      fetchwave_ack <= 1'b0;
      fetch_wfid    <= '0;
      fetch_pc      <= '0;
      fetch_instr   <= '0;
      fetch_first   <= 1'b0;
    end else begin
      mem_req       <= state_nx == REQ;
      mem_addr      <= load ? src_addr : mem_addr;
      hold_tag      <= load ? src_tag : hold_tag;
      hold_kill     <= load ? src_kill : hold_kill || hold_hit;
      buff_ack      <= done;
      fetchwave_ack <= deliver;
      if (deliver) begin
        fetch_wfid  <= hold_tag[37:32];
        fetch_pc    <= hold_tag[31:0];
        fetch_instr <= mem_rsp_data;
        fetch_first <= hold_tag[TAG_W-1];
      end
    end
endmodule

// File: tb/tb_fetch_req_buffer.sv
// tb_fetch_req_buffer: directed scenario tests for fetch_req_buffer.
module tb_fetch_req_buffer;
  logic        clk = 1'b0, rst;
  logic        buff_rd_en, buff_ack, flush_en, mem_req, mem_gnt, mem_rsp_valid;
  logic [31:0] buff_addr, mem_addr, mem_rsp_data, fetch_pc, fetch_instr;
  logic [38:0] buff_tag;
  logic [5:0]  flush_wfid, fetch_wfid;
  logic        fetchwave_ack, fetch_first, overflow_err;
  int n_chk, n_fail, cyc, n_back;
  logic [31:0] q_pc[$], q_instr[$];
  logic [5:0]  q_wfid[$];
  int          q_cyc[$];
  bit          gnt_en, rsp_en, pending;
  logic [31:0] pend_data;
  localparam logic [31:0] K = 32'hA5A5_0000;

  fetch_req_buffer dut (
    .clk(clk), .rst(rst), .buff_rd_en(buff_rd_en), .buff_addr(buff_addr), .buff_tag(buff_tag),
    .buff_ack(buff_ack), .flush_en(flush_en), .flush_wfid(flush_wfid), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .fetchwave_ack(fetchwave_ack), .fetch_wfid(fetch_wfid),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .fetch_first(fetch_first),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle: record outputs, then act as a 1-cycle memory (grant when enabled, respond next cycle).
  task automatic tick();
    if (buff_ack) n_back++;
    if (fetchwave_ack) begin
      q_pc.push_back(fetch_pc);
      q_wfid.push_back(fetch_wfid);
      q_instr.push_back(fetch_instr);
      q_cyc.push_back(cyc);
    end
    mem_rsp_valid = pending && rsp_en;
    mem_rsp_data  = pend_data;
    if (mem_rsp_valid) pending = 1'b0;
    mem_gnt = gnt_en && mem_req && !pending;
    if (mem_gnt) begin
      pending   = 1'b1;
      pend_data = mem_addr ^ K;
    end
    step();
    cyc++;
  endtask

  task automatic push_tick(input logic [5:0] w, input logic [31:0] pc);
    buff_rd_en = 1'b1;
    buff_addr  = pc;
    buff_tag   = {1'b0, w, pc};
    tick();
    buff_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    buff_rd_en = 0; buff_addr = 0; buff_tag = 0; flush_en = 0; flush_wfid = 0;
    mem_gnt = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    step();
    step();
    rst = 1'b0;
    pending = 0; gnt_en = 0; rsp_en = 1; cyc = 0; n_back = 0;
    q_pc.delete(); q_wfid.delete(); q_instr.delete(); q_cyc.delete();
  endtask

  task automatic test_reset();
    logic [135:0] outs;
    do_reset();
    outs = {buff_ack, mem_req, mem_addr, fetchwave_ack, fetch_wfid, fetch_pc, fetch_instr, fetch_first, overflow_err};
    n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
  endtask

  task automatic test_single();
    do_reset();
    buff_rd_en = 1; buff_addr = 32'h100; buff_tag = {1'b1, 6'd5, 32'h100};
    step();
    buff_rd_en = 0;
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL single_req_cyc1: got %b expected 1", mem_req); end
    n_chk++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL single_addr: got %h expected 100", mem_addr); end
    step();
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL single_req_cyc2: got %b expected 1", mem_req); end
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL single_req_cyc3: got %b expected 0", mem_req); end
    step();
    n_chk++; if ({buff_ack, fetchwave_ack} !== 2'b00) begin n_fail++; $display("FAIL single_early_ack: got %b expected 00", {buff_ack, fetchwave_ack}); end
    mem_rsp_valid = 1; mem_rsp_data = 32'hBEEF;
    step();
    mem_rsp_valid = 0;
    n_chk++; if ({buff_ack, fetchwave_ack} !== 2'b11) begin n_fail++; $display("FAIL single_acks_cyc5: got %b expected 11", {buff_ack, fetchwave_ack}); end
    n_chk++; if (fetch_wfid !== 6'd5) begin n_fail++; $display("FAIL single_wfid: got %0d expected 5", fetch_wfid); end
    n_chk++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL single_pc: got %h expected 100", fetch_pc); end
    n_chk++; if (fetch_first !== 1'b1) begin n_fail++; $display("FAIL single_first: got %b expected 1", fetch_first); end
    n_chk++; if (fetch_instr !== 32'hBEEF) begin n_fail++; $display("FAIL single_instr: got %h expected beef", fetch_instr); end
    step();
    n_chk++; if ({buff_ack, fetchwave_ack, mem_req} !== 3'b000) begin n_fail++; $display("FAIL single_after: got %b expected 000", {buff_ack, fetchwave_ack, mem_req}); end
    n_chk++; if (fetch_instr !== 32'hBEEF) begin n_fail++; $display("FAIL single_hold_instr: got %h expected beef", fetch_instr); end
  endtask

  task automatic test_burst();
    do_reset();
    gnt_en = 1;
    for (int i = 0; i < 4; i++) push_tick(6'(i + 1), 32'h200 + 32'(16 * i));
    repeat (12) tick();
    n_chk++; if (q_pc.size() !== 4) begin n_fail++; $display("FAIL burst_count: got %0d expected 4", q_pc.size()); end
    n_chk++; if (n_back !== 4) begin n_fail++; $display("FAIL burst_buff_ack: got %0d expected 4", n_back); end
    for (int k = 0; k < q_pc.size(); k++) begin
      n_chk++; if (q_pc[k] !== 32'h200 + 32'(16 * k)) begin n_fail++; $display("FAIL burst_pc[%0d]: got %h expected %h", k, q_pc[k], 32'h200 + 32'(16 * k)); end
      n_chk++; if (q_instr[k] !== ((32'h200 + 32'(16 * k)) ^ K)) begin n_fail++; $display("FAIL burst_instr[%0d]: got %h", k, q_instr[k]); end
      n_chk++; if (q_cyc[k] !== 3 + 2 * k) begin n_fail++; $display("FAIL burst_cycle[%0d]: got %0d expected %0d", k, q_cyc[k], 3 + 2 * k); end
    end
    n_chk++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL burst_overflow: got %b expected 0", overflow_err); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        n_chk++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b expected 0", overflow_err); end
      end
      push_tick(6'd2, 32'h400 + 32'(16 * i));
    end
    n_chk++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
    gnt_en = 1;
    repeat (16) tick();
    n_chk++; if (q_pc.size() !== 4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", q_pc.size()); end
    for (int k = 0; k < q_pc.size(); k++) begin
      n_chk++; if (q_pc[k] !== 32'h400 + 32'(16 * k)) begin n_fail++; $display("FAIL ovf_pc[%0d]: got %h expected %h", k, q_pc[k], 32'h400 + 32'(16 * k)); end
    end
    n_chk++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) push_tick(6'd1, 32'h500 + 32'(16 * i));
    gnt_en = 1;
    push_tick(6'd1, 32'h540);
    repeat (16) tick();
    n_chk++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL fullpp_overflow: got %b expected 0", overflow_err); end
    n_chk++; if (q_pc.size() !== 5) begin n_fail++; $display("FAIL fullpp_count: got %0d expected 5", q_pc.size()); end
    for (int k = 0; k < q_pc.size(); k++) begin
      n_chk++; if (q_pc[k] !== 32'h500 + 32'(16 * k)) begin n_fail++; $display("FAIL fullpp_pc[%0d]: got %h expected %h", k, q_pc[k], 32'h500 + 32'(16 * k)); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    gnt_en = 1; rsp_en = 0;
    push_tick(6'd3, 32'h600);
    push_tick(6'd3, 32'h610);
    push_tick(6'd7, 32'h620);
    push_tick(6'd3, 32'h630);
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_in_wait: got mem_req %b expected 0", mem_req); end
    flush_en = 1; flush_wfid = 6'd3;
    push_tick(6'd3, 32'h640);
    flush_en = 0; rsp_en = 1;
    repeat (20) tick();
    n_chk++; if (n_back !== 5) begin n_fail++; $display("FAIL flush_buff_ack: got %0d expected 5", n_back); end
    n_chk++; if (q_pc.size() !== 2) begin n_fail++; $display("FAIL flush_delivered: got %0d expected 2", q_pc.size()); end
    if (q_pc.size() == 2) begin
      n_chk++; if (q_pc[0] !== 32'h620 || q_wfid[0] !== 6'd7) begin n_fail++; $display("FAIL flush_first: got pc %h wfid %0d expected 620/7", q_pc[0], q_wfid[0]); end
      n_chk++; if (q_pc[1] !== 32'h640) begin n_fail++; $display("FAIL flush_push_same_cycle: got %h expected 640", q_pc[1]); end
    end
  endtask

  task automatic test_flush_rsp();
    do_reset();
    gnt_en = 1; rsp_en = 0;
    push_tick(6'd9, 32'h700);
    tick();
    tick();
    rsp_en = 1; flush_en = 1; flush_wfid = 6'd9;
    tick();
    flush_en = 0;
    repeat (3) tick();
    n_chk++; if (n_back !== 1) begin n_fail++; $display("FAIL flushrsp_buff_ack: got %0d expected 1", n_back); end
    n_chk++; if (q_pc.size() !== 0) begin n_fail++; $display("FAIL flushrsp_suppressed: got %0d expected 0", q_pc.size()); end
  endtask

  task automatic test_rst_wait();
    logic [135:0] outs;
    do_reset();
    gnt_en = 1;
    push_tick(6'd4, 32'h800);
    repeat (4) tick();
    n_chk++; if (fetch_pc !== 32'h800) begin n_fail++; $display("FAIL rstw_pre_pc: got %h expected 800", fetch_pc); end
    rsp_en = 0;
    push_tick(6'd4, 32'h810);
    tick();
    tick();
    rst = 1;
    #2;
    outs = {buff_ack, mem_req, mem_addr, fetchwave_ack, fetch_wfid, fetch_pc, fetch_instr, fetch_first, overflow_err};
    n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL rstw_async: got %h expected 0", outs); end
    mem_gnt = 0;
    step();
    rst = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h1234;
    step();
    mem_rsp_valid = 0;
    outs = {buff_ack, mem_req, mem_addr, fetchwave_ack, fetch_wfid, fetch_pc, fetch_instr, fetch_first, overflow_err};
    n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL rstw_stray_rsp: got %h expected 0", outs); end
    step();
    n_chk++; if ({buff_ack, fetchwave_ack, mem_req} !== 3'b000) begin n_fail++; $display("FAIL rstw_after: got %b expected 000", {buff_ack, fetchwave_ack, mem_req}); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_flush_rsp();
    test_rst_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
